// File: rtl/i2c_master_arbiter.sv
`timescale 1ns/1ps
// i2c_master_arbiter
//
// Shares one byte-level I2C master engine among NUM_REQ on-chip requesters.
// Requests are granted round-robin. Each grant launches exactly one master
// transaction with a one-cycle enable pulse. The arbiter then follows the
// master's ready handshake and returns the read byte, or a timeout status,
// to the granted requester. SDA/SCL are not touched here.
//
// Handshakes:
//   requester side : req_valid[i] is held with its payload until a one-cycle
//                    req_ready[i] pulse accepts it. The result arrives later
//                    as a one-cycle rsp_valid[i] pulse. rsp_rdata and
//                    rsp_timeout are valid only in that cycle.
//   master side    : m_enable is a one-cycle pulse issued only while m_ready=1.
//                    The master drops m_ready after accepting and raises it
//                    again when done. m_data_out is valid in that cycle.
//
// Ports:
//   clk, rst                     clock, asynchronous active-high reset
//   req_valid/addr/rw/wdata      packed per-requester request payloads
//   req_ready                    one-hot acceptance pulse
//   rsp_valid/rdata/timeout      one-hot completion pulse plus result
//   busy                         high whenever the FSM is not in IDLE
//   m_addr/m_data_in/m_rw        transaction fields driven to the master
//   m_enable                     launch pulse to the master
//   m_data_out, m_ready          read data and idle/done flag from the master
module i2c_master_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 4095,
  parameter int CNT_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*7-1:0] req_addr,
  input  logic [NUM_REQ-1:0]   req_rw,
  input  logic [NUM_REQ*8-1:0] req_wdata,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   rsp_valid,
  output logic [7:0]           rsp_rdata,
  output logic                 rsp_timeout,
  output logic                 busy,
  output logic [6:0]           m_addr,
  output logic [7:0]           m_data_in,
  output logic                 m_rw,
  output logic                 m_enable,
  input  logic [7:0]           m_data_out,
  input  logic                 m_ready
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LAUNCH    = 3'd1,
    WAIT_BUSY = 3'd2,
    WAIT_DONE = 3'd3,
    RESP      = 3'd4
  } state_t;

  // The state register is kept as a named signal for hierarchical probing.
  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] grant;
  logic             lat_rw;
  logic [CNT_W-1:0] cnt;

  logic             pick_found;
  logic [IDX_W-1:0] pick_idx;
  logic [6:0]       pick_addr;
  logic             pick_rw;
  logic [7:0]       pick_wdata;
  logic [CNT_W-1:0] cnt_inc;
  logic             cnt_hit;
  logic [IDX_W-1:0] ptr_next;

  // Round-robin pick. Offsets are scanned from the far end down to 0, so the
  // requester closest to rr_ptr (wrapping around) is assigned last and wins.
  // Requester indices are compared against constants so the payload slices
  // stay static.
  always_comb begin : arb_pick
    int s;
    s          = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_addr  = '0;
    pick_rw    = 1'b0;
    pick_wdata = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      s = int'(rr_ptr) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (s == i && req_valid[i]) begin
          pick_found = 1'b1;
          pick_idx   = IDX_W'(i);
          pick_addr  = req_addr[i*7 +: 7];
          pick_rw    = req_rw[i];
          pick_wdata = req_wdata[i*8 +: 8];
        end
      end
    end
  end

  // The wait-phase counter saturates at TIMEOUT. The timeout fires in the
  // cycle whose increment reaches TIMEOUT, so a phase lasts TIMEOUT cycles.
  always_comb begin
    cnt_inc  = (cnt == CNT_W'(TIMEOUT)) ? cnt : cnt + CNT_W'(1);
    cnt_hit  = (cnt_inc == CNT_W'(TIMEOUT));
    ptr_next = (grant == IDX_W'(NUM_REQ - 1)) ? '0 : grant + IDX_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant       <= '0;
      lat_rw      <= 1'b0;
      cnt         <= '0;
      req_ready   <= '0;
      rsp_valid   <= '0;
      rsp_rdata   <= '0;
      rsp_timeout <= 1'b0;
      busy        <= 1'b0;
      m_addr      <= '0;
      m_data_in   <= '0;
      m_rw        <= 1'b0;
      m_enable    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // No grant while the master is busy. The request stays pending.
          if (pick_found && m_ready) begin
            grant     <= pick_idx;
            lat_rw    <= pick_rw;
            m_addr    <= pick_addr;
            m_rw      <= pick_rw;
            m_data_in <= pick_rw ? 8'h00 : pick_wdata;
            m_enable  <= 1'b1;
            req_ready <= NUM_REQ'(1) << pick_idx;
            busy      <= 1'b1;
            state     <= LAUNCH;
          end
        end
        LAUNCH: begin
          m_enable  <= 1'b0;
          req_ready <= '0;
          cnt       <= '0;
          state     <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          // The master taking the job has priority over a same-cycle timeout.
          if (!m_ready) begin
            cnt   <= '0;
            state <= WAIT_DONE;
          end else if (cnt_hit) begin
            cnt         <= cnt_inc;
            rsp_valid   <= NUM_REQ'(1) << grant;
            rsp_rdata   <= 8'h00;
            rsp_timeout <= 1'b1;
            state       <= RESP;
          end else begin
            cnt <= cnt_inc;
          end
        end
        WAIT_DONE: begin
          if (m_ready) begin
            rsp_valid   <= NUM_REQ'(1) << grant;
            rsp_rdata   <= lat_rw ? m_data_out : 8'h00;
            rsp_timeout <= 1'b0;
            state       <= RESP;
          end else if (cnt_hit) begin
            cnt         <= cnt_inc;
            rsp_valid   <= NUM_REQ'(1) << grant;
            rsp_rdata   <= 8'h00;
            rsp_timeout <= 1'b1;
            state       <= RESP;
          end else begin
            cnt <= cnt_inc;
          end
        end
        RESP: begin
          rsp_valid   <= '0;
          rsp_rdata   <= 8'h00;
          rsp_timeout <= 1'b0;
          busy        <= 1'b0;
          rr_ptr      <= ptr_next;
          state       <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_master_arbiter.sv
`timescale 1ns/1ps
module tb_i2c_master_arbiter;

  localparam int N  = 4;
  localparam int TO = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [N-1:0]   req_valid;
  logic [N*7-1:0] req_addr;
  logic [N-1:0]   req_rw;
  logic [N*8-1:0] req_wdata;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [7:0]     rsp_rdata;
  logic           rsp_timeout;
  logic           busy;
  logic [6:0]     m_addr;
  logic [7:0]     m_data_in;
  logic           m_rw;
  logic           m_enable;
  logic [7:0]     m_data_out;
  logic           m_ready;

  i2c_master_arbiter #(.NUM_REQ(N), .TIMEOUT(TO), .CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_rw      (req_rw),
    .req_wdata   (req_wdata),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_rdata   (rsp_rdata),
    .rsp_timeout (rsp_timeout),
    .busy        (busy),
    .m_addr      (m_addr),
    .m_data_in   (m_data_in),
    .m_rw        (m_rw),
    .m_enable    (m_enable),
    .m_data_out  (m_data_out),
    .m_ready     (m_ready)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  // {rsp_valid[3:0], rsp_timeout, rsp_rdata[7:0], latency_from_enable[7:0]}
  logic [20:0] exp_q[$];
  // {req_ready[3:0], m_enable, m_addr[6:0], m_rw, m_data_in[7:0]}
  logic [20:0] gnt_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_gnt(input logic [3:0] oh, input logic [6:0] a, input logic rw, input logic [7:0] din);
    gnt_q.push_back({oh, 1'b1, a, rw, din});
  endtask

  task automatic push_rsp(input logic [3:0] oh, input logic to, input logic [7:0] rd, input logic [7:0] lat);
    exp_q.push_back({oh, to, rd, lat});
  endtask

  // ---------------- master model ----------------
  int         drop_dly = 1;
  int         busy_len = 1;
  logic [7:0] rd_val = 8'h00;
  int         hang_total = 0;
  int         hang_seen = 0;
  logic       force_low = 1'b0;

  task automatic serve();
    logic [15:0] snap;
    int bad;
    bit aborted;
    snap = {m_addr, m_data_in, m_rw};
    bad = 0;
    aborted = 1'b0;
    for (int c = 0; c < drop_dly; c++) begin
      @(negedge clk);
      if (rst) aborted = 1'b1;
      else if (!aborted && {m_addr, m_data_in, m_rw} !== snap) bad++;
    end
    m_ready = 1'b0;
    for (int c = 0; c < busy_len; c++) begin
      @(negedge clk);
      if (rst) aborted = 1'b1;
      else if (!aborted && {m_addr, m_data_in, m_rw} !== snap) bad++;
    end
    m_data_out = rd_val;
    m_ready = 1'b1;
    if (!aborted) check("fields_held_stable", bad, 0);
  endtask

  initial begin
    m_ready = 1'b1;
    m_data_out = 8'h00;
    forever begin
      @(negedge clk);
      if (force_low) m_ready = 1'b0;
      else if (m_enable && m_ready) begin
        if (hang_seen < hang_total) hang_seen++;
        else serve();
      end else m_ready = 1'b1;
    end
  end

  // ---------------- monitor ----------------
  initial begin
    int last_en;
    bit prev_rsp;
    logic [20:0] e;
    last_en = 0;
    prev_rsp = 1'b0;
    forever begin
      @(negedge clk);
      if (m_enable || req_ready != '0) begin
        if (gnt_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_grant: got %0h expected none", {req_ready, m_enable, m_addr});
        end else begin
          e = gnt_q.pop_front();
          check("grant", {req_ready, m_enable, m_addr, m_rw, m_data_in}, e);
        end
        last_en = cyc;
      end
      if (rsp_valid != '0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: got %0h expected none", {rsp_valid, rsp_timeout, rsp_rdata});
        end else begin
          e = exp_q.pop_front();
          check("response", {rsp_valid, rsp_timeout, rsp_rdata, 8'(cyc - last_en)}, e);
        end
      end
      if (prev_rsp) check("rsp_fields_cleared", {rsp_valid, rsp_timeout, rsp_rdata}, 0);
      prev_rsp = (rsp_valid != '0);
    end
  end

  // ---------------- requester driver ----------------
  int rem[N];

  // Advance to just after the next falling edge. A requester drops its
  // request once it has been accepted the number of times it asked for.
  task automatic tick();
    @(negedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (req_ready[i] && req_valid[i]) begin
        if (rem[i] > 0) rem[i]--;
        if (rem[i] == 0) req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic issue(input int i, input logic [6:0] a, input logic rw, input logic [7:0] wd, input int n);
    req_addr[i*7 +: 7]  = a;
    req_rw[i]           = rw;
    req_wdata[i*8 +: 8] = wd;
    req_valid[i]        = 1'b1;
    rem[i]              = n;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && gnt_q.size() == 0 && !busy && m_ready && req_valid == '0) && n < budget) begin
      tick();
      n++;
    end
    check(name, (n < budget), 1);
    tick();
    tick();
  endtask

  function automatic logic [31:0] all_outs();
    return {13'd0, req_ready, rsp_valid, rsp_timeout, busy, m_rw, m_enable, (|rsp_rdata), (|m_addr), (|m_data_in)};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    logic stray;
    int n;
    rst = 1'b1;
    req_valid = '0;
    req_addr = '0;
    req_rw = '0;
    req_wdata = '0;
    for (int i = 0; i < N; i++) rem[i] = 0;

    // Round robin: all four requesters valid from reset; 0,1,3 ask twice, 2 once.
    drop_dly = 1; busy_len = 1; rd_val = 8'h5A;
    issue(0, 7'h10, 1'b0, 8'hC0, 2);
    issue(1, 7'h11, 1'b1, 8'hC1, 2);
    issue(2, 7'h12, 1'b0, 8'hC2, 1);
    issue(3, 7'h13, 1'b1, 8'hC3, 2);
    repeat (3) tick();
    check("reset_outputs", all_outs(), 0);
    push_gnt(4'b0001, 7'h10, 1'b0, 8'hC0); push_rsp(4'b0001, 1'b0, 8'h00, 8'd3);
    push_gnt(4'b0010, 7'h11, 1'b1, 8'h00); push_rsp(4'b0010, 1'b0, 8'h5A, 8'd3);
    push_gnt(4'b0100, 7'h12, 1'b0, 8'hC2); push_rsp(4'b0100, 1'b0, 8'h00, 8'd3);
    push_gnt(4'b1000, 7'h13, 1'b1, 8'h00); push_rsp(4'b1000, 1'b0, 8'h5A, 8'd3);
    push_gnt(4'b0001, 7'h10, 1'b0, 8'hC0); push_rsp(4'b0001, 1'b0, 8'h00, 8'd3);
    push_gnt(4'b0010, 7'h11, 1'b1, 8'h00); push_rsp(4'b0010, 1'b0, 8'h5A, 8'd3);
    push_gnt(4'b1000, 7'h13, 1'b1, 8'h00); push_rsp(4'b1000, 1'b0, 8'h5A, 8'd3);
    rst = 1'b0;
    wait_idle("round_robin_done", 200);

    // Single write from requester 1: ready drops 2 cycles after enable, busy 10.
    drop_dly = 2; busy_len = 10; rd_val = 8'hEE;
    push_gnt(4'b0010, 7'h50, 1'b0, 8'hA5); push_rsp(4'b0010, 1'b0, 8'h00, 8'd13);
    issue(1, 7'h50, 1'b0, 8'hA5, 1);
    wait_idle("single_write_done", 100);

    // Single read from requester 2, fastest master; wdata must be ignored.
    drop_dly = 1; busy_len = 1; rd_val = 8'h7E;
    push_gnt(4'b0100, 7'h3C, 1'b1, 8'h00); push_rsp(4'b0100, 1'b0, 8'h7E, 8'd3);
    issue(2, 7'h3C, 1'b1, 8'hFF, 1);
    wait_idle("single_read_done", 100);

    // Master not ready in IDLE: request 0 waits, grant follows ready by one cycle.
    force_low = 1'b1;
    tick();
    tick();
    push_gnt(4'b0001, 7'h11, 1'b0, 8'h22); push_rsp(4'b0001, 1'b0, 8'h00, 8'd3);
    issue(0, 7'h11, 1'b0, 8'h22, 1);
    stray = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      stray = stray | m_enable | (|req_ready);
    end
    check("no_grant_while_not_ready", stray, 0);
    force_low = 1'b0;
    tick();
    tick();
    check("grant_after_ready", {m_enable, req_ready}, 5'b1_0001);
    wait_idle("ready_low_done", 100);

    // Timeout in WAIT_BUSY (master ignores one launch), then requester 2 served normally.
    hang_total = hang_total + 1;
    drop_dly = 2; busy_len = 3; rd_val = 8'h99;
    push_gnt(4'b0010, 7'h21, 1'b1, 8'h00); push_rsp(4'b0010, 1'b1, 8'h00, 8'd21);
    push_gnt(4'b0100, 7'h22, 1'b1, 8'h00); push_rsp(4'b0100, 1'b0, 8'h99, 8'd6);
    issue(1, 7'h21, 1'b1, 8'h00, 1);
    issue(2, 7'h22, 1'b1, 8'h00, 1);
    wait_idle("timeout_busy_done", 300);

    // Timeout in WAIT_DONE: master stays busy for 30 cycles.
    drop_dly = 1; busy_len = 30; rd_val = 8'h12;
    push_gnt(4'b1000, 7'h44, 1'b0, 8'h55); push_rsp(4'b1000, 1'b1, 8'h00, 8'd22);
    issue(3, 7'h44, 1'b0, 8'h55, 1);
    wait_idle("timeout_done_done", 200);

    // Move the pointer to 2 so a pointer reset is observable.
    drop_dly = 1; busy_len = 1; rd_val = 8'h00;
    push_gnt(4'b0010, 7'h31, 1'b0, 8'h32); push_rsp(4'b0010, 1'b0, 8'h00, 8'd3);
    issue(1, 7'h31, 1'b0, 8'h32, 1);
    wait_idle("pointer_bump_done", 100);

    // Reset during WAIT_DONE with requesters 0 and 3 pending.
    drop_dly = 1; busy_len = 8; rd_val = 8'h6C;
    push_gnt(4'b0100, 7'h0C, 1'b0, 8'h0E);
    issue(2, 7'h0C, 1'b0, 8'h0E, 1);
    n = 0;
    while (!m_enable && n < 20) begin
      tick();
      n++;
    end
    check("reset_case_launch", m_enable, 1);
    push_gnt(4'b0001, 7'h0A, 1'b0, 8'h0B); push_rsp(4'b0001, 1'b0, 8'h00, 8'd10);
    push_gnt(4'b1000, 7'h0D, 1'b1, 8'h00); push_rsp(4'b1000, 1'b0, 8'h6C, 8'd10);
    issue(0, 7'h0A, 1'b0, 8'h0B, 1);
    issue(3, 7'h0D, 1'b1, 8'h00, 1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("reset_mid_outputs", all_outs(), 0);
    tick();
    rst = 1'b0;
    wait_idle("reset_recovery_done", 200);

    check("queues_empty", exp_q.size() + gnt_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
